// File: rtl/int_to_fp32.sv
// int_to_fp32: multi-cycle 32-bit integer to IEEE-754 float32 converter,
// normalizing one bit per cycle and rounding to nearest-even.
module int_to_fp32 #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  state_t      state_q;
  logic        sign_q;
  logic [7:0]  exp_q;
  logic [31:0] mag_q;
  logic [31:0] out_q;
  logic        sign_d;
  logic [31:0] mag_d;
  logic [23:0] mant_r;
  assign sign_d = SIGNED & in_data[31];
  assign mag_d  = sign_d ? (~in_data + 32'd1) : in_data;
  // Bit 23 of the rounded mantissa is the carry that bumps the exponent
  assign mant_r = {1'b0, mag_q[30:8]} + 24'(mag_q[7] & ((|mag_q[6:0]) | mag_q[8]));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= 8'd0;
      mag_q   <= 32'd0;
      out_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sign_q <= sign_d;
          mag_q  <= mag_d;
          exp_q  <= 8'd158;
          if (mag_d == 32'd0) begin
            out_q   <= 32'd0;
            state_q <= DONE;
          end else state_q <= NORM;
        end
        NORM: if (!mag_q[31]) begin
          mag_q <= mag_q << 1;
          exp_q <= exp_q - 8'd1;
        end else state_q <= ROUND;
        ROUND: begin
          out_q   <= {sign_q, exp_q + 8'(mant_r[23]), mant_r[22:0]};
          state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_data  = out_q;
endmodule
